// File: rtl/line_refill_ctrl.sv
// ----------------------------------------------------------------------------
// line_refill_ctrl
//
// Cache line refill controller. It accepts a miss request, issues one memory
// burst read for the four-word line, and writes each returned beat into the
// word-banked data array. It pulses refill_done for one cycle after the fourth
// beat is written.
//
// Optional feature macro: LINE_REFILL_CRITICAL_WORD_FIRST_EN
//   defined   : the burst starts at the requested word and wraps. The
//               requested word is forwarded on fwd_valid/fwd_data in the same
//               cycle it is written.
//   undefined : the burst starts at word 0 of the line, and the forward
//               outputs are tied to 0.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   miss_valid/ready refill request handshake (ready only while idle)
//   miss_addr        missing byte address: [3:2] word offset, [9:4] set index
//   mem_req/mem_ack  memory read request, held until it is acknowledged
//   mem_addr         burst start address
//   mem_rvalid/rdata read beats returned by memory
//   sel_dataunit_in  one-hot word-bank write select
//   web_data         byte write enables, active-low
//   cs_data          data array chip select
//   addr_index       set index for the data array
//   dataunit_in      write data for the data array
//   fwd_valid/data   requested word forwarded to the core
//   refill_done      one-cycle pulse after the line has been fully written
// ----------------------------------------------------------------------------
module line_refill_ctrl #(
  parameter int DATAWIDTH  = 32,
  parameter int INDEXWIDTH = 6,
  parameter int ADDRWIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [ADDRWIDTH-1:0]  miss_addr,
  output logic                  mem_req,
  output logic [ADDRWIDTH-1:0]  mem_addr,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [DATAWIDTH-1:0]  mem_rdata,
  output logic [3:0]            sel_dataunit_in,
  output logic [3:0]            web_data,
  output logic                  cs_data,
  output logic [INDEXWIDTH-1:0] addr_index,
  output logic [DATAWIDTH-1:0]  dataunit_in,
  output logic                  fwd_valid,
  output logic [DATAWIDTH-1:0]  fwd_data,
  output logic                  refill_done
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL,
    DONE
  } state_t;

  state_t               state;
  state_t               state_d;
  logic [1:0]           beat_cnt;
  logic [1:0]           beat_cnt_d;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [ADDRWIDTH-1:0] addr_d;
  logic [1:0]           start_word;
  logic [1:0]           cur_word;
  logic                 wr_en;
  logic                 unused_addr_bits;

  // State, beat counter and latched miss address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      addr_q   <= '0;
    end else begin
      state    <= state_d;
      beat_cnt <= beat_cnt_d;
      addr_q   <= addr_d;
    end
  end

  // Next-state logic. A write cycle is any FILL cycle that has a valid beat.
  // Gaps in mem_rvalid leave both the counter and the state unchanged.
  always_comb begin
    state_d    = state;
    beat_cnt_d = beat_cnt;
    addr_d     = addr_q;
    wr_en      = 1'b0;
    unique case (state)
      IDLE: begin
        if (miss_valid) begin
          addr_d  = miss_addr;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          beat_cnt_d = '0;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (mem_rvalid) begin
          wr_en      = 1'b1;
          beat_cnt_d = beat_cnt + 2'd1;
          if (beat_cnt == 2'd3) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and data-array outputs. All write-side outputs sit at their
  // inactive values except in a write cycle.
  always_comb begin
    miss_ready      = (state == IDLE);
    mem_req         = (state == REQ);
    refill_done     = (state == DONE);
    cur_word        = start_word + beat_cnt;
    addr_index      = addr_q[4 +: INDEXWIDTH];
    sel_dataunit_in = '0;
    web_data        = '1;
    cs_data         = 1'b0;
    dataunit_in     = '0;
    if (wr_en) begin
      sel_dataunit_in = 4'b0001 << cur_word;
      web_data        = '0;
      cs_data         = 1'b1;
      dataunit_in     = mem_rdata;
    end
  end

`ifdef LINE_REFILL_CRITICAL_WORD_FIRST_EN
  // Wrapping burst: memory returns the requested word first. Within one line
  // the word-offset match therefore occurs only on the first beat.
  always_comb begin
    start_word       = addr_q[3:2];
    mem_addr         = {addr_q[ADDRWIDTH-1:2], 2'b00};
    fwd_valid        = wr_en && (cur_word == addr_q[3:2]);
    fwd_data         = fwd_valid ? mem_rdata : '0;
    unused_addr_bits = ^addr_q[1:0];
  end
`else
  // Line-aligned burst starting at word 0. Nothing is forwarded.
  always_comb begin
    start_word       = 2'd0;
    mem_addr         = {addr_q[ADDRWIDTH-1:4], 4'b0000};
    fwd_valid        = 1'b0;
    fwd_data         = '0;
    unused_addr_bits = ^addr_q[3:0];
  end
`endif

endmodule
